// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared helpers for the parametrised single-clock FIFO.
//   ptr_w()          : address width needed to index DEPTH entries
//   cnt_w()          : occupancy counter width able to hold 0..DEPTH
//   fifo_params_ok() : legality of DATA_W / DEPTH / watermark combination,
//                      evaluated at elaboration time by the top level
//   fifo_acc_t       : accepted read/write strobes for one cycle
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

  typedef struct packed {
    logic wr_acc;
    logic rd_acc;
  } fifo_acc_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // DEPTH must be a power of two so that pointers wrap by plain overflow.
  function automatic bit fifo_params_ok(input int data_w, input int depth,
                                        input int af, input int ae);
    bit ok;
    ok = (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
         (af >= 1) && (af <= depth) && (ae >= 0) && (ae <= depth - 1);
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo_param_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x DATA_W register array with one write port and one registered read
// port. A read and a write to the same address in the same cycle returns the
// old contents (needed when the FIFO is full and both pointers coincide).
// The array itself is never reset; only the read register is cleared.
// Ports:
//   clk    : clock
//   rst    : synchronous active-high reset (clears rdata only)
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   re     : read enable (loads rdata)
//   raddr  : read address
//   rdata  : registered read data, holds when re is low
// -----------------------------------------------------------------------------
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// watermarks, registered read data with a one-cycle valid strobe and defined
// behaviour for simultaneous read/write at the full and empty boundaries.
// All outputs are registered; no combinational path from rd/wr to outputs.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   defined   -> sticky overflow/underflow flags plus err_clr input
//   undefined -> those ports are absent, dropped requests are silently ignored
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   wr, data_in    : write request and data
//   rd             : read request
//   data_out       : registered read data (holds between pops)
//   data_valid     : one-cycle pulse when data_out carries a newly popped word
//   full, empty    : count == DEPTH / count == 0
//   almost_full    : count >= AF_THRESH
//   almost_empty   : count <= AE_THRESH
//   count          : occupancy 0..DEPTH
//   overflow       : sticky, wr while full and not accepted   (macro only)
//   underflow      : sticky, rd while empty                   (macro only)
//   err_clr        : clears overflow/underflow, wins over set  (macro only)
// -----------------------------------------------------------------------------
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       rd,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       err_clr,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  if (!fifo_params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_param: illegal DATA_W/DEPTH/AF_THRESH/AE_THRESH combination");
  end

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  fifo_acc_t        acc;
  logic [CNT_W-1:0] count_nxt;

  // Accept logic: a read frees a slot in the same cycle, so a full FIFO can
  // still take a write alongside a read. An empty FIFO never bypasses.
  always_comb begin
    acc        = '0;
    acc.rd_acc = rd & ~empty;
    acc.wr_acc = wr & (~full | acc.rd_acc);
  end

  always_comb begin
    count_nxt = count;
    case ({acc.wr_acc, acc.rd_acc})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and flags: flags are computed from count_nxt so they
  // switch on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      data_valid   <= 1'b0;
    end else begin
      if (acc.wr_acc) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (acc.rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count        <= count_nxt;
      empty        <= (count_nxt == '0);
      full         <= (count_nxt == CNT_W'(DEPTH));
      almost_full  <= (int'(count_nxt) >= AF_THRESH);
      almost_empty <= (int'(count_nxt) <= AE_THRESH);
      data_valid   <= acc.rd_acc;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (err_clr) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr & full & ~acc.rd_acc) begin
        overflow <= 1'b1;
      end
      if (rd & empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (acc.wr_acc & ~rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .re    (acc.rd_acc),
    .raddr (rd_ptr),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic       rd = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       data_valid, full, empty, almost_full, almost_empty;
  logic [3:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
  logic       err_clr = 1'b0;
`endif

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr           (wr),
    .data_in      (data_in),
    .rd           (rd),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr),
`endif
    .count        (count)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural reference: a queue of stored words plus the last popped word.
  byte unsigned q[$];
  logic [7:0]   m_dout = 8'h00;
  bit           m_vld  = 1'b0;
  bit           m_ov   = 1'b0;
  bit           m_uf   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input bit rq,
                            input logic [7:0] d, input bit clr);
    bit rok, wok;
    if (r) begin
      q.delete();
      m_dout = 8'h00; m_vld = 1'b0; m_ov = 1'b0; m_uf = 1'b0;
    end else begin
      rok = rq && (q.size() > 0);
      wok = w && ((q.size() < DEPTH) || rok);
`ifdef FIFO_ERR_FLAGS_EN
      if (clr) begin
        m_ov = 1'b0; m_uf = 1'b0;
      end else begin
        if (w && (q.size() == DEPTH) && !rok) m_ov = 1'b1;
        if (rq && (q.size() == 0)) m_uf = 1'b1;
      end
`endif
      if (rok) begin
        m_dout = q.pop_front();
        m_vld  = 1'b1;
      end else begin
        m_vld = 1'b0;
      end
      if (wok) q.push_back(d);
    end
  endtask

  // Drive one cycle: inputs set away from the edge, sampled 1 ns after it.
  task automatic cyc(input bit r, input bit w, input bit rq,
                     input logic [7:0] d, input bit clr = 1'b0);
    rst = r; wr = w; rd = rq; data_in = d;
`ifdef FIFO_ERR_FLAGS_EN
    err_clr = clr;
`endif
    @(posedge clk);
    model_step(r, w, rq, d, clr);
    #1;
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"},     32'(count),        32'(n));
    chk({tag, ".empty"},     32'(empty),        32'(n == 0));
    chk({tag, ".full"},      32'(full),         32'(n == DEPTH));
    chk({tag, ".afull"},     32'(almost_full),  32'(n >= AF));
    chk({tag, ".aempty"},    32'(almost_empty), 32'(n <= AE));
    chk({tag, ".data_out"},  32'(data_out),     32'(m_dout));
    chk({tag, ".valid"},     32'(data_valid),   32'(m_vld));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, ".overflow"},  32'(overflow),     32'(m_ov));
    chk({tag, ".underflow"}, 32'(underflow),    32'(m_uf));
`endif
  endtask

  typedef struct {
    bit         rst, wr, rd;
    logic [7:0] din;
    int         ecnt;
    logic [7:0] edout;
    bit         evld;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit w, input bit rq, input logic [7:0] d,
                     input int ec, input logic [7:0] ed, input bit ev);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rq; v.din = d;
    v.ecnt = ec; v.edout = ed; v.evld = ev;
    tbl.push_back(v);
  endtask

  logic [7:0] exp4 [8];

  initial begin
    // Reset, fill 00..07, dropped 9th write, drain, empty rd+wr collision.
    add(1, 0, 0, 8'h00, 0, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(i), i + 1, 8'h00, 0);
    add(0, 1, 0, 8'hFF, 8, 8'h00, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 8'h00, 7 - i, 8'(i), 1);
    add(0, 0, 0, 8'h00, 0, 8'h07, 0);
    add(0, 1, 1, 8'hF0, 1, 8'h07, 0);
    add(0, 0, 1, 8'h00, 0, 8'hF0, 1);
    add(0, 0, 0, 8'h00, 0, 8'hF0, 0);

    foreach (tbl[i]) begin
      cyc(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("vec%0d.count", i),  32'(count),        32'(tbl[i].ecnt));
      chk($sformatf("vec%0d.dout", i),   32'(data_out),     32'(tbl[i].edout));
      chk($sformatf("vec%0d.valid", i),  32'(data_valid),   32'(tbl[i].evld));
      chk($sformatf("vec%0d.full", i),   32'(full),         32'(tbl[i].ecnt == DEPTH));
      chk($sformatf("vec%0d.empty", i),  32'(empty),        32'(tbl[i].ecnt == 0));
      chk($sformatf("vec%0d.afull", i),  32'(almost_full),  32'(tbl[i].ecnt >= AF));
      chk($sformatf("vec%0d.aempty", i), 32'(almost_empty), 32'(tbl[i].ecnt <= AE));
`ifdef FIFO_ERR_FLAGS_EN
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(m_ov));
`endif
    end

    // Full with simultaneous rd+wr: count pinned at DEPTH, oldest popped,
    // new words surface after both pointers wrap.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0, 8'h10 + 8'(i));
      check_model("fill4");
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 1, 8'hA5);
      chk("full_rw.count", 32'(count), 32'd8);
      chk("full_rw.full",  32'(full),  32'd1);
      chk("full_rw.dout",  32'(data_out), 32'(8'h10 + 8'(i)));
      chk("full_rw.valid", 32'(data_valid), 32'd1);
    end
    exp4 = '{8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'hA5, 8'hA5, 8'hA5};
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1, 8'h00);
      chk("drain4.dout", 32'(data_out), 32'(exp4[i]));
      check_model("drain4");
    end
    chk("drain4.empty", 32'(empty), 32'd1);

    // Read while empty: data_out holds, no valid pulse.
    cyc(0, 0, 1, 8'h00);
    chk("rd_empty.dout",  32'(data_out),   32'(8'hA5));
    chk("rd_empty.valid", 32'(data_valid), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rd_empty.underflow", 32'(underflow), 32'd1);
    cyc(0, 0, 0, 8'h00, 1'b1);
    chk("err_clr.overflow",  32'(overflow),  32'd0);
    chk("err_clr.underflow", 32'(underflow), 32'd0);
`endif
    check_model("rd_empty");

    // Reset in mid-stream with a pending write.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h30 + 8'(i));
    chk("pre_rst.count", 32'(count), 32'd5);
    cyc(0, 0, 1, 8'h00);
    cyc(1, 1, 0, 8'h77);
    chk("mid_rst.count", 32'(count),      32'd0);
    chk("mid_rst.empty", 32'(empty),      32'd1);
    chk("mid_rst.valid", 32'(data_valid), 32'd0);
    chk("mid_rst.dout",  32'(data_out),   32'd0);
    cyc(0, 0, 0, 8'h00);
    check_model("post_rst");

    // Randomised traffic with shifting write/read bias.
    for (int p = 0; p < 3; p++) begin
      int wb;
      wb = (p == 0) ? 80 : (p == 1) ? 50 : 20;
      for (int n = 0; n < 1000; n++) begin
        bit r, w, rq, c;
        r  = ($urandom_range(0, 199) == 0);
        w  = ($urandom_range(0, 99) < wb);
        rq = ($urandom_range(0, 99) < (100 - wb));
        c  = ($urandom_range(0, 49) == 0);
        cyc(r, w, rq, 8'($urandom), c);
        check_model("rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
